// File: rtl/icache_pkg.sv
// Shared types and helpers for the set-associative instruction cache controller:
// FSM state encoding, address-field width functions and line word selection.
package icache_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_LOOKUP    = 3'd1,
    ST_MISS_REQ  = 3'd2,
    ST_MISS_WAIT = 3'd3,
    ST_RESP      = 3'd4,
    ST_FLUSH     = 3'd5
  } state_t;

  // Widest line word_sel can take; callers zero-extend narrower lines.
  localparam int MAX_LINE_WORDS = 64;
  localparam int MAX_LINE_BITS  = 32 * MAX_LINE_WORDS;

  function automatic int calc_off_w(input int line_words);
    return 2 + $clog2(line_words);
  endfunction

  function automatic int calc_idx_w(input int sets);
    return $clog2(sets);
  endfunction

  function automatic int calc_tag_w(input int addr_w, input int sets, input int line_words);
    return addr_w - calc_idx_w(sets) - calc_off_w(line_words);
  endfunction

  function automatic int calc_way_w(input int ways);
    return (ways > 1) ? $clog2(ways) : 1;
  endfunction

  function automatic logic [31:0] word_sel(input logic [MAX_LINE_BITS-1:0] line,
                                           input int unsigned off);
    return line[off*32 +: 32];
  endfunction

endpackage

// File: rtl/icache_victim_sel.sv
// Picks the refill victim for one set: the lowest invalid way if there is one,
// otherwise the way named by the set's FIFO pointer.
module icache_victim_sel
  import icache_pkg::*;
#(
  parameter int WAYS  = 4,
  parameter int WAY_W = 2
) (
  input  logic [WAYS-1:0]  i_valid,
  input  logic [WAY_W-1:0] i_fifo_ptr,
  output logic [WAY_W-1:0] o_victim,
  output logic             o_from_fifo
);

  always_comb begin
    o_victim    = i_fifo_ptr;
    o_from_fifo = 1'b1;
    // Scan downwards so the lowest-numbered invalid way wins.
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!i_valid[w]) begin
        o_victim    = WAY_W'(w);
        o_from_fifo = 1'b0;
      end
    end
  end

endmodule

// File: rtl/icache_sa_ctrl.sv
// N-way set-associative instruction cache controller: tag/data/valid arrays,
// hit lookup, req/ack line refill with FIFO replacement, and full-cache flush.
module icache_sa_ctrl
  import icache_pkg::*;
#(
  parameter int  ADDR_W     = 32,
  parameter int  WAYS       = 4,
  parameter int  SETS       = 4,
  parameter int  LINE_WORDS = 4,
  localparam int OFF_W      = calc_off_w(LINE_WORDS),
  localparam int IDX_W      = calc_idx_w(SETS),
  localparam int TAG_W      = calc_tag_w(ADDR_W, SETS, LINE_WORDS),
  localparam int LADDR_W    = ADDR_W - OFF_W
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    cpu_req_i,
  input  logic [ADDR_W-1:0]       cpu_addr_i,
  output logic                    cpu_ready_o,
  output logic                    cpu_valid_o,
  output logic [31:0]             cpu_data_o,
  input  logic                    flush_i,
  output logic                    flush_done_o,
  output logic                    mem_req_o,
  output logic [LADDR_W-1:0]      mem_addr_o,
  input  logic                    mem_ack_i,
  input  logic [32*LINE_WORDS-1:0] mem_data_i,
  output logic                    busy_o,
  output logic                    hit_o,
  output logic                    miss_o
);

  localparam int WO_W   = OFF_W - 2;
  localparam int WAY_W  = calc_way_w(WAYS);
  localparam int LINE_W = 32 * LINE_WORDS;

  state_t r_state, w_state_next;

  logic [TAG_W-1:0]  r_tag;
  logic [IDX_W-1:0]  r_idx;
  logic [WO_W-1:0]   r_off;
  logic [WAYS-1:0]   r_valid    [SETS];
  logic [WAY_W-1:0]  r_fifo_ptr [SETS];
  logic [WAY_W-1:0]  r_victim;
  logic              r_from_fifo;
  logic [IDX_W-1:0]  r_flush_cnt;
  logic              r_cpu_valid;
  logic [31:0]       r_cpu_data;

  logic              w_accept;
  logic              w_refill_we;
  logic              w_flush_last;
  logic              w_hit;
  logic [WAYS-1:0]   w_match;
  logic [WAYS-1:0]   w_set_valid;
  logic [LINE_W-1:0] w_rd_line [WAYS];
  logic [LINE_W-1:0] w_hit_line;
  logic [WAY_W-1:0]  w_victim;
  logic              w_from_fifo;
  logic [WAY_W-1:0]  w_ptr_next;
  logic [TAG_W-1:0]  w_in_tag;
  logic [IDX_W-1:0]  w_in_idx;
  logic [WO_W-1:0]   w_in_off;
  logic [31:0]       w_hit_word;
  logic [31:0]       w_refill_word;
  logic [MAX_LINE_BITS-1:0] w_hit_line_ext;
  logic [MAX_LINE_BITS-1:0] w_refill_line_ext;
  logic              w_unused_addr_bits;

  assign w_in_tag           = cpu_addr_i[ADDR_W-1 -: TAG_W];
  assign w_in_idx           = cpu_addr_i[OFF_W +: IDX_W];
  assign w_in_off           = cpu_addr_i[2 +: WO_W];
  assign w_unused_addr_bits = ^cpu_addr_i[1:0];

  assign w_accept     = cpu_req_i && cpu_ready_o;
  assign w_refill_we  = (r_state == ST_MISS_WAIT) && mem_ack_i;
  assign w_flush_last = (r_flush_cnt == IDX_W'(SETS - 1));
  assign w_set_valid  = r_valid[r_idx];
  assign w_hit        = |w_match;
  assign w_ptr_next   = (r_fifo_ptr[r_idx] == WAY_W'(WAYS - 1)) ? '0
                                                                 : r_fifo_ptr[r_idx] + 1'b1;

  // Per-way tag and data RAMs; the set is read at acceptance so LOOKUP sees
  // registered read data.
  genvar gi;
  generate
    for (gi = 0; gi < WAYS; gi++) begin : g_way
      logic [TAG_W-1:0]  r_tag_mem  [SETS];
      logic [LINE_W-1:0] r_data_mem [SETS];
      logic [TAG_W-1:0]  r_rd_tag;
      logic [LINE_W-1:0] r_rd_line;

      always_ff @(posedge clk) begin
        if (w_refill_we && (r_victim == WAY_W'(gi))) begin
          r_tag_mem[r_idx]  <= r_tag;
          r_data_mem[r_idx] <= mem_data_i;
        end
        if (w_accept) begin
          r_rd_tag  <= r_tag_mem[w_in_idx];
          r_rd_line <= r_data_mem[w_in_idx];
        end
      end

      assign w_rd_line[gi] = r_rd_line;
      assign w_match[gi]   = w_set_valid[gi] && (r_rd_tag == r_tag);
    end
  endgenerate

  always_comb begin
    w_hit_line = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (w_match[w]) begin
        w_hit_line = w_hit_line | w_rd_line[w];
      end
    end
  end

  always_comb begin
    w_hit_line_ext                   = '0;
    w_refill_line_ext                = '0;
    w_hit_line_ext[LINE_W-1:0]       = w_hit_line;
    w_refill_line_ext[LINE_W-1:0]    = mem_data_i;
  end

  assign w_hit_word    = word_sel(w_hit_line_ext, 32'(r_off));
  assign w_refill_word = word_sel(w_refill_line_ext, 32'(r_off));

  icache_victim_sel #(
    .WAYS  (WAYS),
    .WAY_W (WAY_W)
  ) u_victim_sel (
    .i_valid     (w_set_valid),
    .i_fifo_ptr  (r_fifo_ptr[r_idx]),
    .o_victim    (w_victim),
    .o_from_fifo (w_from_fifo)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    cpu_ready_o  = 1'b0;
    flush_done_o = 1'b0;
    mem_req_o    = 1'b0;
    mem_addr_o   = '0;
    busy_o       = (r_state != ST_IDLE);
    hit_o        = 1'b0;
    miss_o       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        cpu_ready_o = !flush_i;
        if (flush_i) begin
          w_state_next = ST_FLUSH;
        end else if (cpu_req_i) begin
          w_state_next = ST_LOOKUP;
        end
      end
      ST_LOOKUP: begin
        hit_o        = w_hit;
        miss_o       = !w_hit;
        w_state_next = w_hit ? ST_IDLE : ST_MISS_REQ;
      end
      ST_MISS_REQ: begin
        mem_req_o    = 1'b1;
        mem_addr_o   = {r_tag, r_idx};
        w_state_next = ST_MISS_WAIT;
      end
      ST_MISS_WAIT: begin
        mem_req_o  = 1'b1;
        mem_addr_o = {r_tag, r_idx};
        if (mem_ack_i) begin
          w_state_next = ST_RESP;
        end
      end
      ST_RESP: begin
        w_state_next = ST_IDLE;
      end
      ST_FLUSH: begin
        flush_done_o = w_flush_last;
        if (w_flush_last) begin
          w_state_next = ST_IDLE;
        end
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_tag       <= '0;
      r_idx       <= '0;
      r_off       <= '0;
      r_victim    <= '0;
      r_from_fifo <= 1'b0;
      r_flush_cnt <= '0;
      r_cpu_valid <= 1'b0;
      r_cpu_data  <= '0;
      for (int s = 0; s < SETS; s++) begin
        r_valid[s]    <= '0;
        r_fifo_ptr[s] <= '0;
      end
    end else begin
      r_cpu_valid <= 1'b0;
      if (w_accept) begin
        r_tag <= w_in_tag;
        r_idx <= w_in_idx;
        r_off <= w_in_off;
      end
      case (r_state)
        ST_LOOKUP: begin
          if (w_hit) begin
            r_cpu_valid <= 1'b1;
            r_cpu_data  <= w_hit_word;
          end
        end
        ST_MISS_REQ: begin
          r_victim    <= w_victim;
          r_from_fifo <= w_from_fifo;
        end
        ST_MISS_WAIT: begin
          if (mem_ack_i) begin
            r_valid[r_idx][r_victim] <= 1'b1;
            // Only a full set advances its pointer; filling an empty way does not.
            if (r_from_fifo) begin
              r_fifo_ptr[r_idx] <= w_ptr_next;
            end
            r_cpu_valid <= 1'b1;
            r_cpu_data  <= w_refill_word;
          end
        end
        ST_FLUSH: begin
          r_valid[r_flush_cnt]    <= '0;
          r_fifo_ptr[r_flush_cnt] <= '0;
          r_flush_cnt             <= w_flush_last ? '0 : r_flush_cnt + 1'b1;
        end
        default: begin
        end
      endcase
    end
  end

  assign cpu_valid_o = r_cpu_valid;
  assign cpu_data_o  = r_cpu_data;

  always_ff @(posedge clk) begin
    if (!reset && (r_state == ST_LOOKUP)) begin
      assert ($onehot0(w_match));
    end
  end

endmodule

// File: tb/tb_icache_sa_ctrl.sv
// Bench for icache_sa_ctrl: directed vector table, hand-written corner sequences,
// then random fetches checked against a per-set resident-line model.
module tb_icache_sa_ctrl;

  localparam int ADDR_W     = 32;
  localparam int WAYS       = 4;
  localparam int SETS       = 4;
  localparam int LINE_WORDS = 4;
  localparam int OFF_W      = 4;
  localparam int LADDR_W    = ADDR_W - OFF_W;
  localparam int LINE_W     = 32 * LINE_WORDS;

  logic                clk = 1'b0;
  logic                reset = 1'b1;
  logic                cpu_req_i = 1'b0;
  logic [ADDR_W-1:0]   cpu_addr_i = '0;
  logic                flush_i = 1'b0;
  logic                mem_ack_i = 1'b0;
  logic [LINE_W-1:0]   mem_data_i = '0;
  logic                cpu_ready_o, cpu_valid_o, flush_done_o, mem_req_o;
  logic                busy_o, hit_o, miss_o;
  logic [31:0]         cpu_data_o;
  logic [LADDR_W-1:0]  mem_addr_o;

  icache_sa_ctrl #(
    .ADDR_W     (ADDR_W),
    .WAYS       (WAYS),
    .SETS       (SETS),
    .LINE_WORDS (LINE_WORDS)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .cpu_req_i    (cpu_req_i),
    .cpu_addr_i   (cpu_addr_i),
    .cpu_ready_o  (cpu_ready_o),
    .cpu_valid_o  (cpu_valid_o),
    .cpu_data_o   (cpu_data_o),
    .flush_i      (flush_i),
    .flush_done_o (flush_done_o),
    .mem_req_o    (mem_req_o),
    .mem_addr_o   (mem_addr_o),
    .mem_ack_i    (mem_ack_i),
    .mem_data_i   (mem_data_i),
    .busy_o       (busy_o),
    .hit_o        (hit_o),
    .miss_o       (miss_o)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Backing memory: every line address has a distinct, reproducible content.
  function automatic logic [31:0] mem_word(input logic [LADDR_W-1:0] la, input int w);
    return (32'(la) * 32'h9E37_79B1) ^ (32'(w) * 32'h0101_0101) ^ 32'h5A00_0000;
  endfunction

  function automatic logic [LINE_W-1:0] mem_line(input logic [LADDR_W-1:0] la);
    logic [LINE_W-1:0] l;
    for (int w = 0; w < LINE_WORDS; w++) l[w*32 +: 32] = mem_word(la, w);
    return l;
  endfunction

  // Reference model: per set, resident line addresses in fill order plus a
  // round-robin replacement pointer used once the set is full.
  logic [LADDR_W-1:0] m_line [SETS][WAYS];
  int                 m_fill [SETS];
  int                 m_ptr  [SETS];

  function automatic bit m_lookup(input logic [LADDR_W-1:0] la);
    int s = int'(la % SETS);
    for (int w = 0; w < m_fill[s]; w++) if (m_line[s][w] == la) return 1'b1;
    return 1'b0;
  endfunction

  task automatic m_refill(input logic [LADDR_W-1:0] la);
    int s = int'(la % SETS);
    if (m_fill[s] < WAYS) begin
      m_line[s][m_fill[s]] = la;
      m_fill[s]++;
    end else begin
      m_line[s][m_ptr[s]] = la;
      m_ptr[s] = (m_ptr[s] + 1) % WAYS;
    end
  endtask

  task automatic m_clear();
    for (int s = 0; s < SETS; s++) begin
      m_fill[s] = 0;
      m_ptr[s]  = 0;
    end
  endtask

  // Continues a fetch whose request is already on the bus in an IDLE cycle.
  task automatic finish_fetch(input logic [31:0] addr, input int d, input bit exp_hit);
    logic [LADDR_W-1:0] la = addr[ADDR_W-1:OFF_W];
    logic [31:0] exp_w = mem_word(la, int'(addr[OFF_W-1:2]));
    @(posedge clk); #1 cpu_req_i = 1'b0;
    @(negedge clk);
    chk("hit_o", hit_o, exp_hit);
    chk("miss_o", miss_o, !exp_hit);
    if (exp_hit) begin
      @(posedge clk); @(negedge clk);
      chk("hit_valid", cpu_valid_o, 1);
      chk("hit_data", cpu_data_o, exp_w);
      chk("hit_no_memreq", mem_req_o, 0);
    end else begin
      @(posedge clk); @(negedge clk);
      chk("miss_memreq", mem_req_o, 1);
      chk("miss_memaddr", mem_addr_o, la);
      for (int i = 0; i < d; i++) begin
        @(posedge clk); @(negedge clk);
        chk("wait_memreq", mem_req_o, 1);
        chk("wait_memaddr", mem_addr_o, la);
        chk("wait_novalid", cpu_valid_o, 0);
      end
      @(posedge clk); #1 mem_ack_i = 1'b1; mem_data_i = mem_line(la);
      @(posedge clk); #1 mem_ack_i = 1'b0; mem_data_i = {4{$urandom()}};
      @(negedge clk);
      chk("refill_valid", cpu_valid_o, 1);
      chk("refill_data", cpu_data_o, exp_w);
      chk("refill_memreq_drop", mem_req_o, 0);
      m_refill(la);
    end
    $display("fetch addr=%08h %s data=%08h", addr, exp_hit ? "hit " : "miss", cpu_data_o);
  endtask

  task automatic fetch(input logic [31:0] addr, input int d, input bit exp_hit);
    @(posedge clk); #1 cpu_req_i = 1'b1; cpu_addr_i = addr;
    @(negedge clk);
    chk("ready_idle", cpu_ready_o, 1);
    chk("valid_is_pulse", cpu_valid_o, 0);
    finish_fetch(addr, d, exp_hit);
  endtask

  task automatic do_flush();
    @(posedge clk); #1 flush_i = 1'b1;
    @(negedge clk);
    chk("ready_low_on_flush", cpu_ready_o, 0);
    @(posedge clk); #1 flush_i = 1'b0;
    for (int c = 0; c < SETS; c++) begin
      @(negedge clk);
      chk("flush_busy", busy_o, 1);
      chk("flush_done", flush_done_o, (c == SETS - 1));
    end
    @(posedge clk); @(negedge clk);
    chk("flush_end_busy", busy_o, 0);
    chk("flush_end_done", flush_done_o, 0);
    m_clear();
    $display("flush over %0d cycles", SETS);
  endtask

  typedef enum logic {OP_FETCH, OP_FLUSH} op_e;
  typedef struct {
    op_e         op;
    logic [31:0] addr;
    int          dly;
    bit          exp_hit;
  } vec_t;

  function automatic vec_t mk(input op_e op, input logic [31:0] addr, input int dly, input bit h);
    vec_t v;
    v.op = op; v.addr = addr; v.dly = dly; v.exp_hit = h;
    return v;
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t tbl[$];
    // Cold miss, hits, set-1 fill and FIFO eviction order, then flush and refill.
    tbl.push_back(mk(OP_FETCH, 32'h048, 3, 0));
    tbl.push_back(mk(OP_FETCH, 32'h048, 0, 1));
    tbl.push_back(mk(OP_FETCH, 32'h04C, 0, 1));
    tbl.push_back(mk(OP_FETCH, 32'h010, 0, 0));
    tbl.push_back(mk(OP_FETCH, 32'h050, 1, 0));
    tbl.push_back(mk(OP_FETCH, 32'h090, 2, 0));
    tbl.push_back(mk(OP_FETCH, 32'h0D0, 0, 0));
    tbl.push_back(mk(OP_FETCH, 32'h014, 0, 1));
    tbl.push_back(mk(OP_FETCH, 32'h110, 0, 0));
    tbl.push_back(mk(OP_FETCH, 32'h050, 0, 1));
    tbl.push_back(mk(OP_FETCH, 32'h010, 0, 0));
    tbl.push_back(mk(OP_FETCH, 32'h090, 0, 1));
    tbl.push_back(mk(OP_FETCH, 32'h050, 0, 0));
    tbl.push_back(mk(OP_FETCH, 32'h0D4, 0, 1));
    tbl.push_back(mk(OP_FETCH, 32'h118, 0, 1));
    tbl.push_back(mk(OP_FETCH, 32'h090, 0, 0));
    tbl.push_back(mk(OP_FETCH, 32'h0D0, 0, 0));
    tbl.push_back(mk(OP_FETCH, 32'h020, 0, 0));
    tbl.push_back(mk(OP_FETCH, 32'h034, 0, 0));
    tbl.push_back(mk(OP_FETCH, 32'h024, 0, 1));
    tbl.push_back(mk(OP_FLUSH, 32'h000, 0, 0));
    tbl.push_back(mk(OP_FETCH, 32'h048, 0, 0));
    tbl.push_back(mk(OP_FETCH, 32'h020, 0, 0));
    tbl.push_back(mk(OP_FETCH, 32'h010, 0, 0));
    tbl.push_back(mk(OP_FETCH, 32'h050, 0, 0));
    tbl.push_back(mk(OP_FETCH, 32'h090, 0, 0));
    tbl.push_back(mk(OP_FETCH, 32'h0D0, 0, 0));
    tbl.push_back(mk(OP_FETCH, 32'h110, 0, 0));
    tbl.push_back(mk(OP_FETCH, 32'h054, 0, 1));
    tbl.push_back(mk(OP_FETCH, 32'h010, 0, 0));
    tbl.push_back(mk(OP_FETCH, 32'h0FF, 0, 0));
    tbl.push_back(mk(OP_FETCH, 32'h0F3, 0, 1));

    m_clear();
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", cpu_ready_o, 1);
    chk("rst_valid", cpu_valid_o, 0);
    chk("rst_data", cpu_data_o, 0);
    chk("rst_memreq", mem_req_o, 0);
    chk("rst_memaddr", mem_addr_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_hit", hit_o, 0);
    chk("rst_miss", miss_o, 0);
    chk("rst_flush_done", flush_done_o, 0);
    @(posedge clk); #1 reset = 1'b0;

    foreach (tbl[i]) begin
      if (tbl[i].op == OP_FLUSH) do_flush();
      else fetch(tbl[i].addr, tbl[i].dly, tbl[i].exp_hit);
    end

    // Flush and fetch requested together: flush wins, fetch waits for it.
    @(posedge clk); #1 flush_i = 1'b1; cpu_req_i = 1'b1; cpu_addr_i = 32'h048;
    @(negedge clk);
    chk("prio_ready", cpu_ready_o, 0);
    @(posedge clk); #1 flush_i = 1'b0;
    for (int c = 0; c < SETS; c++) begin
      @(negedge clk);
      chk("prio_ready_flush", cpu_ready_o, 0);
      chk("prio_busy", busy_o, 1);
      chk("prio_no_lookup", hit_o | miss_o, 0);
      chk("prio_done", flush_done_o, (c == SETS - 1));
    end
    @(posedge clk); @(negedge clk);
    chk("prio_ready_after", cpu_ready_o, 1);
    m_clear();
    $display("flush with pending fetch complete");
    finish_fetch(32'h048, 0, 0);

    // Reset in MISS_WAIT, then a stale ack.
    fetch(32'h048, 0, 1);
    @(posedge clk); #1 cpu_req_i = 1'b1; cpu_addr_i = 32'h200;
    @(posedge clk); #1 cpu_req_i = 1'b0;
    @(negedge clk);
    chk("rstw_miss", miss_o, 1);
    @(posedge clk);
    @(posedge clk); #1 reset = 1'b1;
    @(negedge clk);
    chk("rstw_memreq_before", mem_req_o, 1);
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    chk("rstw_memreq_after", mem_req_o, 0);
    chk("rstw_busy_after", busy_o, 0);
    @(posedge clk);
    @(posedge clk); #1 mem_ack_i = 1'b1; mem_data_i = mem_line(28'h20);
    @(posedge clk); #1 mem_ack_i = 1'b0;
    @(negedge clk);
    chk("late_ack_novalid", cpu_valid_o, 0);
    chk("late_ack_busy", busy_o, 0);
    @(negedge clk);
    chk("late_ack_novalid2", cpu_valid_o, 0);
    m_clear();
    $display("reset during refill, late ack dropped");
    fetch(32'h048, 0, 0);

    // Long ack delay, then a spurious ack while idle.
    fetch(32'h308, 10, 0);
    @(posedge clk); #1 mem_ack_i = 1'b1; mem_data_i = {4{32'hDEAD_BEEF}};
    @(posedge clk); #1 mem_ack_i = 1'b0;
    @(negedge clk);
    chk("spur_busy", busy_o, 0);
    chk("spur_valid", cpu_valid_o, 0);
    $display("spurious ack while idle");
    fetch(32'h300, 0, 1);
    fetch(32'h048, 0, 1);

    // Random fetches with occasional flushes against the model.
    for (int n = 0; n < 200; n++) begin
      if ($urandom_range(0, 19) == 0) begin
        do_flush();
      end else begin
        logic [31:0] a = 32'($urandom_range(0, 1023));
        fetch(a, int'($urandom_range(0, 3)), m_lookup(a[ADDR_W-1:OFF_W]));
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/icache_sa_ctrl.md
Name: icache_sa_ctrl

Overview:
Parametrised N-way set-associative instruction-cache controller with its own tag, valid and data arrays. It sits between the fetch stage and the instruction-memory port. It performs hit lookup, line refill over a req/ack memory handshake, FIFO replacement when a set is full, and a full-cache flush.

Parameters:
ADDR_W, 32, CPU byte-address width.
WAYS, 4, associativity; power of 2, range 1..16.
SETS, 4, number of sets; power of 2, at least 2.
LINE_WORDS, 4, 32-bit words per line; power of 2, at least 2.
Derived localparams: OFF_W = 2 + log2(LINE_WORDS); IDX_W = log2(SETS); TAG_W = ADDR_W - IDX_W - OFF_W; LADDR_W = ADDR_W - OFF_W.

Ports:
clk  in  1  clock; all logic on posedge.
reset  in  1  synchronous, active-high reset.
cpu_req_i  in  1  fetch request; accepted when cpu_req_i and cpu_ready_o are both high.
cpu_addr_i  in  ADDR_W  fetch byte address; bits [1:0] ignored.
cpu_ready_o  out  1  controller can accept a request.
cpu_valid_o  out  1  one-cycle pulse; cpu_data_o is valid.
cpu_data_o  out  32  instruction word.
flush_i  in  1  invalidate request.
flush_done_o  out  1  one-cycle pulse when a flush finishes.
mem_req_o  out  1  line refill request; held high until ack.
mem_addr_o  out  LADDR_W  line address (cpu_addr >> OFF_W).
mem_ack_i  in  1  refill data valid; one-cycle pulse.
mem_data_i  in  32*LINE_WORDS  refill line; word 0 is in the LSBs.
busy_o  out  1  high in any state other than IDLE.
hit_o, miss_o  out  1  one-cycle pulses from LOOKUP, for performance counters.

Behaviour:
- States: IDLE, LOOKUP, MISS_REQ, MISS_WAIT, RESP, FLUSH.
- Reset values:
  - state = IDLE.
  - Every output = 0, except cpu_ready_o, which is 1 (it is combinational on state IDLE).
  - All valid bits and all per-set FIFO pointers = 0.
  - Tag and data arrays are not reset.
- cpu_ready_o = (state == IDLE) && !flush_i.
- Transitions from IDLE:
  - flush_i high -> FLUSH. flush_i has priority over cpu_req_i.
  - Otherwise an accepted request -> LOOKUP, and cpu_addr_i is latched as tag, index and word offset.
- LOOKUP: compare the latched tag against all WAYS entries of the set; an entry matches only if its valid bit is set.
  - Hit: hit_o = 1. cpu_data_o is loaded from the matching way and word, cpu_valid_o pulses on the next cycle, and the state goes to IDLE. Hit latency is 2 cycles from acceptance to cpu_valid_o.
  - Miss: miss_o = 1 and the state goes to MISS_REQ.
  - More than one matching way is illegal; the design asserts this in simulation.
- MISS_REQ: select the victim.
  - If any way in the set is invalid, use the lowest-numbered invalid way.
  - Otherwise use fifo_ptr[set].
  - Drive mem_req_o = 1 and mem_addr_o = {tag, index}, then go to MISS_WAIT.
- MISS_WAIT:
  - mem_req_o and mem_addr_o stay stable until mem_ack_i.
  - On mem_ack_i: write the data, tag and valid bit into the victim way, and drop mem_req_o on the next cycle.
  - fifo_ptr[set] increments (wrapping modulo WAYS) only when the victim came from the pointer, i.e. the set was full.
  - Load cpu_data_o with the requested word from mem_data_i and go to RESP.
- RESP: cpu_valid_o = 1 for one cycle, then IDLE. Refill latency is ack + 1 cycle.
- mem_ack_i outside MISS_WAIT is ignored, with no state change.
- FLUSH:
  - A set counter runs 0..SETS-1, clearing the valid bits of all ways in one set per cycle, and resets that set's fifo_ptr.
  - After the last set: flush_done_o pulses and the state returns to IDLE. Duration is SETS cycles.
  - flush_i while busy is ignored; the requester must hold it until cpu_ready_o would be high.
- Reset during any state, including MISS_WAIT:
  - The next cycle is IDLE with mem_req_o = 0 and all lines invalid.
  - A late mem_ack_i is ignored.
- The data array is written only on refill; there are no partial-line writes.

Decomposition:
- Package icache_pkg holds:
  - the state enum (typedef enum logic [2:0]);
  - localparam functions for OFF_W, IDX_W and TAG_W;
  - the word-select function that picks the 32-bit word at an offset from a line.
- One sub-module, icache_victim_sel (combinational).
  - Inputs: the valid vector of one set and that set's fifo_ptr.
  - Outputs: the victim way index and a from_fifo flag.

Test Plan:
1. Cold miss to 0x0000_0048 (set 0, word 2) -> mem_addr_o = 0x4. Ack after 3 cycles with data = {W3,W2,W1,W0} -> cpu_valid_o one cycle after ack, cpu_data_o = W2. A repeat fetch of 0x48 -> hit_o, cpu_valid_o 2 cycles after acceptance, no mem_req_o.
2. Misses to 0x010, 0x050, 0x090 and 0x0D0 (all set 1) -> these fill ways 0..3. A miss to 0x110 evicts way 0. Fetching 0x010 then misses and evicts way 1, confirming the FIFO order.
3. Fill 3 sets, then pulse flush_i -> busy_o for 4 cycles and flush_done_o on the 4th. Every previously cached address then misses, and victims start again at way 0.
4. flush_i and cpu_req_i both high in IDLE -> FLUSH is entered, cpu_ready_o stays 0 throughout, and the fetch is accepted only after flush_done_o.
5. Assert reset for 1 cycle during MISS_WAIT -> mem_req_o = 0 the next cycle. A mem_ack_i 2 cycles later is ignored (no cpu_valid_o). The earlier hit line now misses.
6. Hold mem_ack_i off for 10 cycles -> mem_req_o and mem_addr_o stay stable throughout. A spurious mem_ack_i while IDLE -> no state change and no array write.
